// File: rtl/demux1ne8_seq_pkg.sv
// -----------------------------------------------------------------------------
// demux1ne8_seq_pkg
// Shared constants for the serial-to-parallel 1:8 demultiplexer: frame length,
// bit-index width, FSM state encodings and a small bit-insert helper.
// -----------------------------------------------------------------------------
package demux1ne8_seq_pkg;

  localparam int FRAME_BITS = 8;
  localparam int IDX_W      = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    PRANIM = 1'b1
  } state_e;

  // Return 'word' with bit 'idx' replaced by 'val'.
  function automatic logic [FRAME_BITS-1:0] set_bit(
    input logic [FRAME_BITS-1:0] word,
    input logic [IDX_W-1:0]      idx,
    input logic                  val
  );
    logic [FRAME_BITS-1:0] res;
    res      = word;
    res[idx] = val;
    return res;
  endfunction

endpackage

// File: rtl/demux1ne8_seq_numrues3bit.sv
// -----------------------------------------------------------------------------
// numrues3bit
// 3-bit bit-index counter with synchronous clear and count enable.
// Ports:
//   Clock   - rising-edge clock
//   ResetN  - asynchronous active-low reset (counter -> 0)
//   clr_i   - synchronous clear
//   en_i    - count enable
//   cnt_o   - current count (registered)
// When clr_i and en_i are both high the counter loads 1: the clear restarts
// the frame and the enable accounts for the bit captured in that same cycle.
// -----------------------------------------------------------------------------
module numrues3bit
  import demux1ne8_seq_pkg::*;
(
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] cnt_o
);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  // Next count: clear wins, then increment (wraps 7 -> 0 at end of frame).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {2'b00, en_i};
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux1ne8_seq.sv
// -----------------------------------------------------------------------------
// demux1ne8_seq
// Serial-to-parallel 1:8 demultiplexer. Collects 8 serial bits (bit 0 first,
// marked by Fillo) into a shadow register and publishes the complete word on
// Dalja with a valid/acknowledge handshake.
// Ports:
//   Clock       - rising-edge clock
//   ResetN      - asynchronous active-low reset
//   Fillo       - start-of-frame, qualified by HyrjaValid
//   Hyrja       - serial data bit
//   HyrjaValid  - qualifies Hyrja/Fillo
//   Lexo        - consumer acknowledge
//   Dalja       - assembled word
//   DaljaValid  - Dalja holds an unacknowledged word
//   S           - index of the next bit to capture
//   Gabim       - one-cycle framing-error pulse (restart mid-frame)
//   Tejkalim    - sticky overrun flag
// -----------------------------------------------------------------------------
module demux1ne8_seq
  import demux1ne8_seq_pkg::*;
(
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Fillo,
  input  logic                  Hyrja,
  input  logic                  HyrjaValid,
  input  logic                  Lexo,
  output logic [FRAME_BITS-1:0] Dalja,
  output logic                  DaljaValid,
  output logic [IDX_W-1:0]      S,
  output logic                  Gabim,
  output logic                  Tejkalim
);

  state_e                state_q;
  logic [FRAME_BITS-1:0] shadow_q;
  logic [FRAME_BITS-1:0] dalja_q;
  logic                  dvalid_q;
  logic                  gabim_q;
  logic                  tejk_q;

  logic [IDX_W-1:0]      idx_s;
  logic                  start_s;
  logic                  bit_s;
  logic                  last_s;
  logic                  ack_s;
  logic                  cnt_clr_s;
  logic                  cnt_en_s;

  // Decode the qualified input events for this cycle.
  always_comb begin
    start_s   = HyrjaValid & Fillo;
    bit_s     = HyrjaValid & ~Fillo & (state_q == PRANIM);
    last_s    = bit_s & (idx_s == 3'd7);
    ack_s     = Lexo & dvalid_q;
    // A start (in either state) clears and counts bit 0 at once -> S=1.
    cnt_clr_s = start_s;
    cnt_en_s  = start_s | bit_s;
  end

  numrues3bit u_idx (
    .Clock  (Clock),
    .ResetN (ResetN),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .cnt_o  (idx_s)
  );

  // Frame FSM, shadow capture and output handshake.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      shadow_q <= 8'h00;
      dalja_q  <= 8'h00;
      dvalid_q <= 1'b0;
      gabim_q  <= 1'b0;
      tejk_q   <= 1'b0;
    end else begin
      gabim_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_s) begin
            shadow_q <= {7'b0000000, Hyrja};
            state_q  <= PRANIM;
          end else begin
            state_q  <= IDLE;
          end
        end
        PRANIM: begin
          if (start_s) begin
            // Restart mid-frame: flag it and begin a fresh word.
            gabim_q  <= 1'b1;
            shadow_q <= {7'b0000000, Hyrja};
            state_q  <= PRANIM;
          end else if (last_s) begin
            shadow_q <= 8'h00;
            state_q  <= IDLE;
          end else if (bit_s) begin
            shadow_q <= set_bit(shadow_q, idx_s, Hyrja);
            state_q  <= PRANIM;
          end else begin
            state_q  <= PRANIM;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Completion takes priority over acknowledge; an ack in the same
      // cycle only suppresses the overrun flag.
      if (last_s) begin
        dalja_q  <= {Hyrja, shadow_q[6:0]};
        dvalid_q <= 1'b1;
        if (dvalid_q && !Lexo) begin
          tejk_q <= 1'b1;
        end else begin
          tejk_q <= tejk_q;
        end
      end else if (ack_s) begin
        dvalid_q <= 1'b0;
        tejk_q   <= 1'b0;
      end else begin
        dvalid_q <= dvalid_q;
      end
    end
  end

  assign Dalja      = dalja_q;
  assign DaljaValid = dvalid_q;
  assign S          = idx_s;
  assign Gabim      = gabim_q;
  assign Tejkalim   = tejk_q;

endmodule

// File: doc/demux1ne8_seq.md
DEMUX1NE8_SEQ -- requirements
Module: demux1ne8_seq

Interface
REQ-001 Parameters: none; frame length is fixed at 8 bits and the index width at 3 bits.
REQ-002 Clock  input  1  single rising-edge clock for all state.
REQ-003 ResetN  input  1  asynchronous, active-low reset.
REQ-004 Fillo  input  1  start-of-frame; the bit sampled with Fillo=1 is bit 0.
REQ-005 Hyrja  input  1  serial data bit, MSB-last (bit 0 first).
REQ-006 HyrjaValid  input  1  qualifies Hyrja and Fillo; both are ignored when it is 0.
REQ-007 Lexo  input  1  consumer acknowledge of the presented word.
REQ-008 Dalja  output  8  assembled word.
REQ-009 DaljaValid  output  1  Dalja holds an unacknowledged word.
REQ-010 S  output  3  index of the next bit to be captured (mirrors the sender's 8:1 select).
REQ-011 Gabim  output  1  one-cycle pulse on a framing error.
REQ-012 Tejkalim  output  1  sticky overrun flag.

Function
REQ-013 The FSM SHALL have states IDLE and PRANIM; the block starts in IDLE with S=0.
REQ-014 IDLE: on HyrjaValid&Fillo, capture Hyrja into shadow bit 0, set S=1, go to PRANIM; all other inputs leave the state unchanged.
REQ-015 PRANIM: on HyrjaValid&!Fillo, capture Hyrja into shadow bit S and set S=S+1.
REQ-016 PRANIM: HyrjaValid=0 holds S, the shadow register, and the state.
REQ-017 When bit 7 is captured: copy the shadow (with bit 7) to Dalja, set DaljaValid=1 on the next edge, set S=0, return to IDLE; latency is 1 cycle from the bit-7 sample to the word being visible.
REQ-018 PRANIM with HyrjaValid&Fillo: pulse Gabim for 1 cycle, discard the partial word, capture Hyrja as bit 0, set S=1, remain in PRANIM.
REQ-019 Lexo while DaljaValid=1 clears DaljaValid and Tejkalim next edge; Lexo while DaljaValid=0 is ignored.
REQ-020 If a word completes while DaljaValid=1 and Lexo=0: overwrite Dalja, keep DaljaValid=1, set Tejkalim=1.
REQ-021 If a word completes in the same cycle as Lexo: load the new word, keep DaljaValid=1, leave Tejkalim unchanged (no overrun).
REQ-022 Dalja SHALL change only on word completion, never on partial capture.

Reset
REQ-023 ResetN=0 SHALL immediately force: state=IDLE, S=0, shadow=0, Dalja=8'h00, DaljaValid=0, Gabim=0, Tejkalim=0.
REQ-024 Reset mid-frame discards the partial word; the first frame after deassertion SHALL start only on HyrjaValid&Fillo.

Structure
REQ-025 The shared constants package SHALL hold FRAME_BITS=8, the index width=3, and the state encodings IDLE/PRANIM.
REQ-026 The bit-index counter SHALL be one sub-module, numrues3bit (3-bit counter with clear and enable, async active-low reset).

Verification
REQ-027 Bits 1,0,1,1,0,0,1,0 (Fillo on the first bit, HyrjaValid continuous) -> Dalja=8'h4D, DaljaValid=1 one cycle after the last bit, Gabim=0.
REQ-028 Same frame with HyrjaValid=0 for 3 cycles after bit 3 -> S holds at 4 during the gap, result still 8'h4D.
REQ-029 Fillo reasserted at bit 5, then frame 8'hA5 -> one Gabim pulse, Dalja=8'hA5, no intermediate word.
REQ-030 Two frames 8'h4D then 8'h3C with no Lexo -> Dalja=8'h3C, DaljaValid=1, Tejkalim=1; one Lexo pulse -> both flags 0.
REQ-031 Lexo asserted in the bit-7 cycle of frame 8'hFF while 8'h4D is pending -> Dalja=8'hFF, DaljaValid=1, Tejkalim=0.
REQ-032 ResetN low at bit 4 of a frame -> all outputs 0 asynchronously; the following frame 8'h81 after reset -> Dalja=8'h81.
